// File: rtl/mtr_ramp_ctrl.sv
// Rate-limited drive-magnitude sequencer with hall supervision.
// Optional stall detection is built when MTR_STALL_DET_EN is defined.
module mtr_ramp_ctrl #(
  parameter int unsigned STEP      = 4,
  parameter int unsigned TICK_DIV  = 1024,
  parameter int unsigned STALL_CYC = 2_000_000,
  parameter logic [11:0] STALL_MIN = 12'h100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] tgt_mag,
  input  logic        brake_n,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  input  logic        clr_fault,
  output logic [11:0] drv_mag,
  output logic [2:0]  state,
  output logic        fault,
  output logic        stall
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    RUN   = 3'd2,
    BRAKE = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [11:0] STEP12 = 12'(STEP);

  state_t        state_q, state_d;
  logic [11:0]   drv_q, drv_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          fault_q, fault_d;
  logic          stall_q, stall_d;
  logic          inv_q;
  logic [2:0]    hs1, hall;
  logic [11:0]   eff, stepped;
  logic          hall_bad, inv_hit, stall_hit;
  logic          tick_wrap, active;

  // Synchronizer flops carry no reset so the code is valid on release
  always_ff @(posedge clk) begin
    hs1  <= {hallGrn, hallYlw, hallBlu};
    hall <= hs1;
  end

  assign hall_bad  = (hall == 3'b000) || (hall == 3'b111);
  assign inv_hit   = hall_bad && inv_q;
  assign eff       = en ? tgt_mag : 12'd0;
  assign tick_wrap = (tick_q == TICK_LAST);
  assign active    = (state_q == RAMP) || (state_q == RUN);

`ifdef MTR_STALL_DET_EN
  localparam int SW = $clog2(STALL_CYC + 1);
  logic [SW-1:0] scnt_q, scnt_d;
  logic [2:0]    hall_prev;

  always_ff @(posedge clk) begin
    hall_prev <= hall;
  end

  always_comb begin
    scnt_d    = '0;
    stall_hit = 1'b0;
    if (active && drv_q >= STALL_MIN && hall == hall_prev) begin
      scnt_d    = scnt_q + 1'b1;
      stall_hit = (scnt_q == SW'(STALL_CYC - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) scnt_q <= '0;
    else        scnt_q <= scnt_d;
  end
`else
  assign stall_hit = 1'b0;
`endif

  // One rate-limited step toward eff, saturating exactly at eff
  always_comb begin
    stepped = drv_q;
    if (eff > drv_q) begin
      if (eff - drv_q <= STEP12) stepped = eff;
      else                       stepped = drv_q + STEP12;
    end else if (eff < drv_q) begin
      if (drv_q - eff <= STEP12) stepped = eff;
      else                       stepped = drv_q - STEP12;
    end
  end

  always_comb begin
    state_d = state_q;
    drv_d   = drv_q;
    fault_d = fault_q;
    stall_d = stall_q;
    tick_d  = '0;
    if (active) tick_d = tick_wrap ? '0 : tick_q + 1'b1;
    if (state_q != FAULT && (inv_hit || stall_hit)) begin
      state_d = FAULT;
      drv_d   = '0;
      tick_d  = '0;
      fault_d = 1'b1;
      stall_d = !inv_hit;
    end else if (state_q != FAULT && state_q != BRAKE && !brake_n) begin
      state_d = BRAKE;
      drv_d   = '0;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          drv_d = '0;
          if (en && brake_n && tgt_mag != 12'd0) state_d = RAMP;
        end
        RAMP: begin
          if (tick_wrap) begin
            drv_d = stepped;
            if (stepped == eff)
              state_d = (eff == 12'd0) ? IDLE : RUN;
          end
        end
        RUN: begin
          if (eff != drv_q) state_d = RAMP;
        end
        BRAKE: begin
          drv_d = '0;
          if (brake_n) state_d = IDLE;
        end
        FAULT: begin
          drv_d = '0;
          if (clr_fault && !en) begin
            state_d = IDLE;
            fault_d = 1'b0;
            stall_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          drv_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drv_q   <= '0;
      tick_q  <= '0;
      fault_q <= 1'b0;
      stall_q <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drv_q   <= drv_d;
      tick_q  <= tick_d;
      fault_q <= fault_d;
      stall_q <= stall_d;
      inv_q   <= hall_bad;
    end
  end

  assign drv_mag = drv_q;
  assign state   = state_q;
  assign fault   = fault_q;
  assign stall   = stall_q;

endmodule
